// File: rtl/serial_word_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_word_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Bit counter width able to hold 0..w-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rx_shift_core.sv
// Direction-selectable serial-in/parallel-out register with bit counter.
// done is high while the shift in progress is the last bit of the word.
module rx_shift_core
  import serial_word_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             shift,
  input  logic             dir,
  input  logic             si,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  // Clear on frame start, otherwise shift one bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (start) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift) begin
      if (dir == DIR_LSB_FIRST) begin
        data <= {si, data[WIDTH-1:1]};
      end else begin
        data <= {data[WIDTH-2:0], si};
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_rx.sv
// Receive end of the USR serial link: framed bitstream to WIDTH-bit words
// with valid/ready handoff, framing-error and overrun pulses.
// Optional parity check enabled by defining PARITY_CHECK_EN.
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             si,
  input  logic             dir,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  state_t           state;
  logic             dir_q;
  logic             start;
  logic             shift;
  logic             done;
  logic [WIDTH-1:0] data;
  logic             word_ok;

  assign start = (state == IDLE) && !si;
  assign shift = (state == DATA);
  assign busy  = (state != IDLE);

  rx_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .shift (shift),
    .dir   (dir_q),
    .si    (si),
    .data  (data),
    .done  (done)
  );

  // Frame sequencing; direction is captured with the start bit.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      dir_q <= DIR_MSB_FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (!si) begin
            state <= DATA;
            dir_q <= dir;
          end
        end
        DATA: begin
          if (done) begin
`ifdef PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: state <= STOP;
`endif
        STOP:    state <= si ? IDLE : BREAK;
        BREAK:   if (si) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_acc;
  logic par_bad;

  // Even parity over data bits, then compare with the received parity bit.
  always_ff @(posedge clk) begin
    if (!clr) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (start) begin
        par_acc <= 1'b0;
      end else if (shift) begin
        par_acc <= par_acc ^ si;
      end
      if (state == PARITY) begin
        par_bad <= (si != par_acc);
      end
    end
  end

  assign word_ok = !par_bad;
`else
  assign word_ok    = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Output holding register, handshake and one-cycle error pulses.
  // A commit on the consuming edge overrides the valid clear below it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      po        <= '0;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
      if (state == STOP) begin
        if (!si) begin
          frame_err <= 1'b1;
        end else if (!word_ok) begin
`ifdef PARITY_CHECK_EN
          parity_err <= 1'b1;
`endif
        end else if (!po_valid || po_ready) begin
          po       <= data;
          po_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed table-driven bench for serial_word_rx (WIDTH=4, parity check off).
// Each vector is one rising edge: inputs driven before it, outputs expected after it.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       si = 1'b1;
  logic       dir = 1'b0;
  logic       po_ready = 1'b1;
  logic [3:0] po;
  logic       po_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       clr;
    logic       si;
    logic       dir;
    logic       rdy;
    logic [3:0] po;
    logic       v;
    logic       b;
    logic       f;
    logic       o;
  } vec_t;

  vec_t tv[$];

  serial_word_rx #(.WIDTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .si         (si),
    .dir        (dir),
    .po         (po),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic c, input logic s, input logic d, input logic r,
                     input logic [3:0] p, input logic v, input logic b,
                     input logic f, input logic o);
    vec_t x;
    x.clr = c; x.si = s; x.dir = d; x.rdy = r;
    x.po = p; x.v = v; x.b = b; x.f = f; x.o = o;
    tv.push_back(x);
  endtask

  task automatic step(input logic c, input logic s, input logic d, input logic r);
    @(negedge clk);
    clr = c; si = s; dir = d; po_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] p, input logic v,
                       input logic b, input logic f, input logic o);
    n_vec++;
    if ({po, po_valid, busy, frame_err, overrun, parity_err} !== {p, v, b, f, o, 1'b0}) begin
      n_err++;
      $display("FAIL %s: got po=%b valid=%b busy=%b ferr=%b ovr=%b perr=%b, expected po=%b valid=%b busy=%b ferr=%b ovr=%b perr=0",
               name, po, po_valid, busy, frame_err, overrun, parity_err, p, v, b, f, o);
    end
  endtask

  // Start bit, four data bits MSB first, then the given stop bit (dir=0).
  task automatic send_frame(input logic [3:0] w, input logic stop_bit, input logic r);
    logic [3:0] wv;
    wv = w;
    step(1'b1, 1'b0, 1'b0, r);
    for (int i = 3; i >= 0; i--) step(1'b1, wv[i], 1'b0, r);
    step(1'b1, stop_bit, 1'b0, r);
  endtask

  initial begin
    // clr si dir rdy | po valid busy ferr ovr
    // reset
    add(0,1,0,1, 4'b0000,0,0,0,0); add(0,1,0,1, 4'b0000,0,0,0,0);
    // 1: dir=0, stream 1,1,0,1,1,0,1,1 -> 1101
    add(1,1,0,1, 4'b0000,0,0,0,0); add(1,1,0,1, 4'b0000,0,0,0,0);
    add(1,0,0,1, 4'b0000,0,1,0,0);
    add(1,1,0,1, 4'b0000,0,1,0,0); add(1,1,0,1, 4'b0000,0,1,0,0);
    add(1,0,0,1, 4'b0000,0,1,0,0); add(1,1,0,1, 4'b0000,0,1,0,0);
    add(1,1,0,1, 4'b1101,1,0,0,0);
    add(1,1,0,1, 4'b1101,0,0,0,0);
    // 2: dir=1 at start only, same data -> 1011
    add(1,0,1,1, 4'b1101,0,1,0,0);
    add(1,1,0,1, 4'b1101,0,1,0,0); add(1,1,0,1, 4'b1101,0,1,0,0);
    add(1,0,0,1, 4'b1101,0,1,0,0); add(1,1,0,1, 4'b1101,0,1,0,0);
    add(1,1,0,1, 4'b1011,1,0,0,0);
    add(1,1,0,1, 4'b1011,0,0,0,0);
    // 3: 1101 with stop 0 -> frame_err, BREAK holds, then 0110
    add(1,0,0,1, 4'b1011,0,1,0,0);
    add(1,1,0,1, 4'b1011,0,1,0,0); add(1,1,0,1, 4'b1011,0,1,0,0);
    add(1,0,0,1, 4'b1011,0,1,0,0); add(1,1,0,1, 4'b1011,0,1,0,0);
    add(1,0,0,1, 4'b1011,0,1,1,0);
    add(1,0,0,1, 4'b1011,0,1,0,0); add(1,0,0,1, 4'b1011,0,1,0,0);
    add(1,1,0,1, 4'b1011,0,0,0,0);
    add(1,0,0,1, 4'b1011,0,1,0,0);
    add(1,0,0,1, 4'b1011,0,1,0,0); add(1,1,0,1, 4'b1011,0,1,0,0);
    add(1,1,0,1, 4'b1011,0,1,0,0); add(1,0,0,1, 4'b1011,0,1,0,0);
    add(1,1,0,1, 4'b0110,1,0,0,0);
    add(1,1,0,1, 4'b0110,0,0,0,0);
    // 4: po_ready=0, back-to-back 1101 then 0011 -> overrun once
    add(1,0,0,0, 4'b0110,0,1,0,0);
    add(1,1,0,0, 4'b0110,0,1,0,0); add(1,1,0,0, 4'b0110,0,1,0,0);
    add(1,0,0,0, 4'b0110,0,1,0,0); add(1,1,0,0, 4'b0110,0,1,0,0);
    add(1,1,0,0, 4'b1101,1,0,0,0);
    add(1,0,0,0, 4'b1101,1,1,0,0);
    add(1,0,0,0, 4'b1101,1,1,0,0); add(1,0,0,0, 4'b1101,1,1,0,0);
    add(1,1,0,0, 4'b1101,1,1,0,0); add(1,1,0,0, 4'b1101,1,1,0,0);
    add(1,1,0,0, 4'b1101,1,0,0,1);
    add(1,1,0,0, 4'b1101,1,0,0,0);
    add(1,1,0,1, 4'b1101,0,0,0,0);
    // 5: commit of 0011 on the edge consuming 1101
    add(1,0,0,0, 4'b1101,0,1,0,0);
    add(1,1,0,0, 4'b1101,0,1,0,0); add(1,1,0,0, 4'b1101,0,1,0,0);
    add(1,0,0,0, 4'b1101,0,1,0,0); add(1,1,0,0, 4'b1101,0,1,0,0);
    add(1,1,0,0, 4'b1101,1,0,0,0);
    add(1,0,0,0, 4'b1101,1,1,0,0);
    add(1,0,0,0, 4'b1101,1,1,0,0); add(1,0,0,0, 4'b1101,1,1,0,0);
    add(1,1,0,0, 4'b1101,1,1,0,0); add(1,1,0,0, 4'b1101,1,1,0,0);
    add(1,1,0,1, 4'b0011,1,0,0,0);
    add(1,1,0,1, 4'b0011,0,0,0,0);
    // 6: clr mid-DATA, then 1001
    add(1,0,0,1, 4'b0011,0,1,0,0);
    add(1,1,0,1, 4'b0011,0,1,0,0);
    add(0,0,0,1, 4'b0000,0,0,0,0);
    add(1,1,0,1, 4'b0000,0,0,0,0);
    add(1,0,0,1, 4'b0000,0,1,0,0);
    add(1,1,0,1, 4'b0000,0,1,0,0); add(1,0,0,1, 4'b0000,0,1,0,0);
    add(1,0,0,1, 4'b0000,0,1,0,0); add(1,1,0,1, 4'b0000,0,1,0,0);
    add(1,1,0,1, 4'b1001,1,0,0,0);
    add(1,1,0,1, 4'b1001,0,0,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].clr, tv[i].si, tv[i].dir, tv[i].rdy);
      check($sformatf("vec%0d", i), tv[i].po, tv[i].v, tv[i].b, tv[i].f, tv[i].o);
    end

    // Reset while a word is held and a frame is in progress clears everything.
    send_frame(4'b1010, 1'b1, 1'b0);
    check("hold_1010", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_frame", 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_held", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("after_clr", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error while a word is held leaves the held word untouched.
    send_frame(4'b1100, 1'b1, 1'b0);
    check("hold_1100", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0101, 1'b0, 1'b0);
    check("ferr_held", 4'b1100, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("break_exit", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("consume_1100", 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
